mem_latency_bridge: RTL and testbench
=====================================

MEM_LATENCY_BRIDGE -- requirements
Module: mem_latency_bridge

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4: number of cycles main memory needs per access (legal range 1..15).
REQ-002 SHALL have clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_b  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have core_addr  input  32: byte address from the core data port.
REQ-005 SHALL have core_wdata  input  8x4 bytes [0:3]: store data from the core; byte 0 at the lowest address.
REQ-006 SHALL have core_read_en  input  1: core requests a word read.
REQ-007 SHALL have core_write_en  input  1: core requests a word write.
REQ-008 SHALL have core_rdata  output  8x4 bytes [0:3]: data from the last completed read.
REQ-009 SHALL have core_stall  output  1: freezes the core pipeline while an access is outstanding.
REQ-010 SHALL have core_done  output  1: one-cycle pulse when an access completes.
REQ-011 SHALL have ram_addr  output  32: word-aligned address to main memory.
REQ-012 SHALL have ram_wdata  output  8x4 bytes [0:3]: write data to main memory.
REQ-013 SHALL have ram_we  output  1: main-memory write strobe.
REQ-014 SHALL have ram_rdata  input  8x4 bytes [0:3]: main-memory read data, valid in the final latency cycle.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 In IDLE with core_read_en or core_write_en high, core_stall SHALL be 1 combinationally in the same cycle.
REQ-017 On that edge, the block SHALL latch core_addr, core_wdata and the op type, load cnt=MEM_LATENCY-1, and enter BUSY.
REQ-018 When core_read_en and core_write_en are both high, the block SHALL serve the write only and drop the read.
REQ-019 ram_addr SHALL equal {latched_addr[31:2],2'b00} throughout BUSY, and 0 in IDLE.
REQ-020 In BUSY, core_stall SHALL be 1 and cnt SHALL decrement each cycle while non-zero.
REQ-021 In BUSY with cnt==0 on a write: ram_we=1 and ram_wdata=latched data for exactly that cycle, then go to DONE.
REQ-022 In BUSY with cnt==0 on a read: capture ram_rdata into core_rdata on that edge, then go to DONE.
REQ-023 ram_we SHALL be 0 in every other state and cycle.
REQ-024 In DONE, core_done=1 and core_stall=0, then unconditionally go to IDLE; requests present in DONE are ignored.
REQ-025 Latency: a request first seen in IDLE at cycle t SHALL produce core_done at cycle t+MEM_LATENCY+1.
REQ-026 core_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-027 The request inputs SHALL be ignored in BUSY, so a changed core_addr mid-access does not affect the access.
REQ-028 The 4-bit counter SHALL never wrap; MEM_LATENCY=1 gives a single BUSY cycle.

Reset
REQ-029 rst_b low SHALL immediately force: state IDLE, cnt=0, core_rdata all bytes 0, latched address/data/op 0, ram_we=0, core_done=0.
REQ-030 Reset asserted during BUSY SHALL abort the access, with no ram_we pulse after reset and no core_done.
REQ-031 After rst_b rises, the first request SHALL be accepted from IDLE normally.

Verification
REQ-032 Read, MEM_LATENCY=4: read_en at cycle 0 with addr 0x0000_0103, ram_rdata={AA,BB,CC,DD} -> ram_addr 0x0000_0100, stall high cycles 0-4, done pulse cycle 5, core_rdata={AA,BB,CC,DD}.
REQ-033 Write, MEM_LATENCY=4: write_en, addr 0x40, wdata {01,02,03,04} -> ram_we high only in cycle 4 with ram_wdata {01,02,03,04}; core_rdata unchanged.
REQ-034 Simultaneous read_en and write_en -> one write performed, core_rdata unchanged, single done pulse.
REQ-035 Reset pulse at the second BUSY cycle of a write -> ram_we never asserted, no done, state IDLE; a following read completes in MEM_LATENCY+1 cycles.
REQ-036 MEM_LATENCY=1, back-to-back reads held high -> done every 3 cycles (IDLE, BUSY, DONE), with stall low only in DONE cycles.

Source files
------------

// File: rtl/mem_latency_bridge.sv
// rtl/mem_latency_bridge.sv - stalls the core while a fixed-latency main-memory word access completes
module mem_latency_bridge #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [31:0]      core_addr,
    input  logic [0:3][7:0]  core_wdata,
    input  logic             core_read_en,
    input  logic             core_write_en,
    output logic [0:3][7:0]  core_rdata,
    output logic             core_stall,
    output logic             core_done,
    output logic [31:0]      ram_addr,
    output logic [0:3][7:0]  ram_wdata,
    output logic             ram_we,
    input  logic [0:3][7:0]  ram_rdata
);

    // Counter starts at latency-1 so the access spends exactly MEM_LATENCY cycles in BUSY.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [31:0]      latched_addr;
    logic [0:3][7:0]  latched_wdata;
    logic             latched_write;

    logic             core_req;
    logic             last_cycle;

    assign core_req   = core_read_en | core_write_en;
    assign last_cycle = (state == BUSY) && (cnt == 4'd0);

    // Access sequencer: accept in IDLE, count down in BUSY, one-cycle DONE acknowledge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            latched_addr  <= 32'd0;
            latched_wdata <= '0;
            latched_write <= 1'b0;
            core_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        latched_addr  <= core_addr;
                        latched_wdata <= core_wdata;
                        // A write wins over a simultaneous read; the read is dropped.
                        latched_write <= core_write_en;
                        cnt           <= CNT_LOAD;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!latched_write) begin
                            core_rdata <= ram_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Requests seen here are ignored; the core re-presents them in IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; stall also covers the request cycle in IDLE.
    always_comb begin
        core_stall = (state == BUSY) || ((state == IDLE) && core_req);
        core_done  = (state == DONE);
        ram_we     = last_cycle && latched_write;
        ram_addr   = (state == BUSY) ? (latched_addr & ~32'h3) : 32'd0;
        ram_wdata  = ram_we ? latched_wdata : '0;
    end

endmodule

// File: tb/tb_mem_latency_bridge.sv
// tb/tb_mem_latency_bridge.sv - directed self-checking bench for mem_latency_bridge
`timescale 1ns/1ps
module tb_mem_latency_bridge;

    logic             clk;
    logic             rst_b;

    // Instance with default latency 4
    logic [31:0]      core_addr;
    logic [0:3][7:0]  core_wdata;
    logic             core_read_en;
    logic             core_write_en;
    logic [0:3][7:0]  core_rdata;
    logic             core_stall;
    logic             core_done;
    logic [31:0]      ram_addr;
    logic [0:3][7:0]  ram_wdata;
    logic             ram_we;
    logic [0:3][7:0]  ram_rdata;

    // Instance with latency 1
    logic [31:0]      core_addr1;
    logic [0:3][7:0]  core_wdata1;
    logic             core_read_en1;
    logic             core_write_en1;
    logic [0:3][7:0]  core_rdata1;
    logic             core_stall1;
    logic             core_done1;
    logic [31:0]      ram_addr1;
    logic [0:3][7:0]  ram_wdata1;
    logic             ram_we1;
    logic [0:3][7:0]  ram_rdata1;

    int n_checks;
    int n_pass;

    mem_latency_bridge #(.MEM_LATENCY(4)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_read_en  (core_read_en),
        .core_write_en (core_write_en),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .core_done     (core_done),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_rdata     (ram_rdata)
    );

    mem_latency_bridge #(.MEM_LATENCY(1)) dut1 (
        .clk           (clk),
        .rst_b         (rst_b),
        .core_addr     (core_addr1),
        .core_wdata    (core_wdata1),
        .core_read_en  (core_read_en1),
        .core_write_en (core_write_en1),
        .core_rdata    (core_rdata1),
        .core_stall    (core_stall1),
        .core_done     (core_done1),
        .ram_addr      (ram_addr1),
        .ram_wdata     (ram_wdata1),
        .ram_we        (ram_we1),
        .ram_rdata     (ram_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on the latency-4 instance; request presented in cycle 0 only.
    // Bus inputs are scrambled afterwards, and a request is raised in the DONE cycle to prove it is ignored.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] exp_ram_addr,
                              input logic [31:0] wd, input logic [31:0] rdv);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                core_read_en  = rd;
                core_write_en = wr;
                core_addr     = a;
                core_wdata    = wd;
            end else begin
                core_read_en  = (c == 5);
                core_write_en = 1'b0;
                core_addr     = 32'hFFFF_FFF0;
                core_wdata    = 32'hFFFF_FFFF;
            end
            ram_rdata = (c == 4) ? rdv : 32'hDEAD_BEEF;
            @(negedge clk);
            check($sformatf("%s stall c%0d", name, c), 32'(core_stall), 32'(c <= 4));
            check($sformatf("%s done c%0d", name, c), 32'(core_done), 32'(c == 5));
            check($sformatf("%s ram_we c%0d", name, c), 32'(ram_we), 32'(wr && c == 4));
            check($sformatf("%s ram_addr c%0d", name, c), ram_addr,
                  (c >= 1 && c <= 4) ? exp_ram_addr : 32'd0);
            if (wr && c == 4)
                check($sformatf("%s ram_wdata", name), ram_wdata, wd);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst_b          = 1'b0;
        core_addr      = '0;
        core_wdata     = '0;
        core_read_en   = 1'b0;
        core_write_en  = 1'b0;
        ram_rdata      = '0;
        core_addr1     = '0;
        core_wdata1    = '0;
        core_read_en1  = 1'b0;
        core_write_en1 = 1'b0;
        ram_rdata1     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst rdata", core_rdata, 32'h0);
        check("rst stall", 32'(core_stall), 32'h0);
        check("rst done", 32'(core_done), 32'h0);
        check("rst ram_we", 32'(ram_we), 32'h0);
        check("rst ram_addr", ram_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Latency 1, read held high: IDLE, BUSY, DONE repeating
        @(posedge clk);
        #1;
        core_read_en1 = 1'b1;
        core_addr1    = 32'h0000_0007;
        ram_rdata1    = 32'h1234_5678;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("l1 stall c%0d", c), 32'(core_stall1), 32'(c % 3 != 2));
            check($sformatf("l1 done c%0d", c), 32'(core_done1), 32'(c % 3 == 2));
            check($sformatf("l1 ram_we c%0d", c), 32'(ram_we1), 32'h0);
            check($sformatf("l1 ram_addr c%0d", c), ram_addr1, (c % 3 == 1) ? 32'h4 : 32'h0);
        end
        @(posedge clk);
        #1;
        core_read_en1 = 1'b0;
        @(negedge clk);
        check("l1 rdata", core_rdata1, 32'h1234_5678);

        // Read, unaligned address
        run_access("rd", 1'b1, 1'b0, 32'h0000_0103, 32'h0000_0100, 32'h0, 32'hAABB_CCDD);
        check("rd rdata", core_rdata, 32'hAABB_CCDD);

        // Write does not disturb core_rdata
        run_access("wr", 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0102_0304, 32'h1122_3344);
        check("wr rdata", core_rdata, 32'hAABB_CCDD);

        // Simultaneous read and write: write only
        run_access("rw", 1'b1, 1'b1, 32'h0000_0085, 32'h0000_0084, 32'hCAFE_F00D, 32'h5566_7788);
        check("rw rdata", core_rdata, 32'hAABB_CCDD);

        // Reset in the second BUSY cycle of a write
        @(posedge clk);
        #1;
        core_write_en = 1'b1;
        core_addr     = 32'h0000_0200;
        core_wdata    = 32'h9988_7766;
        @(posedge clk);
        #1;
        core_write_en = 1'b0;
        @(negedge clk);
        check("rst_busy stall1", 32'(core_stall), 32'h1);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check("rst_busy stall", 32'(core_stall), 32'h0);
        check("rst_busy ram_we", 32'(ram_we), 32'h0);
        check("rst_busy done", 32'(core_done), 32'h0);
        check("rst_busy ram_addr", ram_addr, 32'h0);
        check("rst_busy rdata", core_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post_rst ram_we c%0d", c), 32'(ram_we), 32'h0);
            check($sformatf("post_rst done c%0d", c), 32'(core_done), 32'h0);
            check($sformatf("post_rst stall c%0d", c), 32'(core_stall), 32'h0);
        end

        // First request after reset is served normally
        run_access("rd2", 1'b1, 1'b0, 32'h0000_010C, 32'h0000_010C, 32'h0, 32'h0BAD_CAFE);
        check("rd2 rdata", core_rdata, 32'h0BAD_CAFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
